// File: rtl/seg7_scroll_driver.sv
// Multiplexed 7-segment driver with a writable message buffer and a scroll engine.
// Optional macro DIM_EN adds a brightness input and 3-bit PWM dimming of the segments.
module seg7_scroll_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int MSG_DEPTH   = 32,
    parameter int SCAN_DIV    = 65536,
    parameter int SCROLL_DIV  = 50000000,
    parameter int PAUSE_TICKS = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [4:0]                   wr_data,
    input  logic [$clog2(MSG_DEPTH):0]   msg_len,
    input  logic                         scroll_en,
`ifdef DIM_EN
    input  logic [2:0]                   brightness,
`endif
    output logic                         scroll_wrap,
    output logic [$clog2(MSG_DEPTH)-1:0] offset,
    output logic [NUM_DIGITS-1:0]        grounds,
    output logic [6:0]                   display,
    output logic [1:0]                   fsm_state
);

    localparam int AW  = $clog2(MSG_DEPTH);
    localparam int DW  = $clog2(NUM_DIGITS);
    localparam int SCW = $clog2(SCAN_DIV);
    localparam int ROW = $clog2(SCROLL_DIV);
    localparam int PW  = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
    localparam logic [AW:0] ND_LEN = (AW+1)'(NUM_DIGITS);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

    state_t          state;
    logic [SCW-1:0]  scan_cnt;
    logic [ROW-1:0]  scroll_cnt;
    logic [PW-1:0]   pause_cnt;
    logic [DW-1:0]   digit;
    logic            scan_tick;
    logic            scroll_tick;
    logic            active;
    logic [AW:0]     max_off;
    logic [AW:0]     idx;
    logic [4:0]      entry;
    logic            blank;
    logic            lit;
    logic [4:0]      mem [MSG_DEPTH];

    function automatic logic [6:0] hex_glyph(input logic [3:0] h);
        logic [6:0] g;
        case (h)
            4'h0: g = 7'h01;
            4'h1: g = 7'h4F;
            4'h2: g = 7'h12;
            4'h3: g = 7'h06;
            4'h4: g = 7'h4C;
            4'h5: g = 7'h24;
            4'h6: g = 7'h20;
            4'h7: g = 7'h0F;
            4'h8: g = 7'h00;
            4'h9: g = 7'h04;
            4'hA: g = 7'h08;
            4'hB: g = 7'h60;
            4'hC: g = 7'h31;
            4'hD: g = 7'h42;
            4'hE: g = 7'h30;
            default: g = 7'h38;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign scan_tick   = (scan_cnt == SCW'(SCAN_DIV - 1));
    assign scroll_tick = (scroll_cnt == ROW'(SCROLL_DIV - 1));
    assign active      = scroll_en && (msg_len > ND_LEN);
    assign max_off     = active ? (msg_len - ND_LEN) : '0;
    assign fsm_state   = state;

    // Window index is one bit wider than offset so it never wraps into the buffer.
    assign idx   = {1'b0, offset} + (AW+1)'(digit);
    assign entry = mem[idx[AW-1:0]];
    assign blank = idx[AW] || (idx >= msg_len) || entry[4];

`ifdef DIM_EN
    logic [2:0] pwm;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm <= 3'd0;
        else        pwm <= pwm + 3'd1;
    end
    assign lit = !blank && (pwm <= brightness);
`else
    assign lit = !blank;
`endif

    // digit leads by one clk; grounds and display are registered together from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            digit    <= '0;
            grounds  <= NUM_DIGITS'(1);
            display  <= 7'h7F;
        end else begin
            scan_cnt <= scan_tick ? '0 : scan_cnt + SCW'(1);
            if (scan_tick)
                digit <= (digit == DW'(NUM_DIGITS - 1)) ? '0 : digit + DW'(1);
            grounds <= NUM_DIGITS'(1) << digit;
            display <= lit ? hex_glyph(entry[3:0]) : 7'h7F;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            offset      <= '0;
            scroll_cnt  <= '0;
            pause_cnt   <= '0;
            scroll_wrap <= 1'b0;
        end else begin
            scroll_wrap <= 1'b0;
            if (!active) begin
                state      <= IDLE;
                scroll_cnt <= '0;
                pause_cnt  <= '0;
                if (msg_len <= ND_LEN) offset <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= RUN;
                        scroll_cnt <= '0;
                    end
                    RUN, PAUSE: begin
                        scroll_cnt <= scroll_tick ? '0 : scroll_cnt + ROW'(1);
                        if (scroll_tick) begin
                            if (state == RUN) begin
                                // >= also catches an offset stranded past a shrunken msg_len.
                                if ({1'b0, offset} >= max_off) begin
                                    offset      <= '0;
                                    scroll_wrap <= 1'b1;
                                    pause_cnt   <= '0;
                                    if (PAUSE_TICKS > 0) state <= PAUSE;
                                end else begin
                                    offset <= offset + AW'(1);
                                end
                            end else if (pause_cnt == PW'(PAUSE_TICKS - 1)) begin
                                state <= RUN;
                            end else begin
                                pause_cnt <= pause_cnt + PW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
